trng_health_test: RTL and testbench

- Online entropy health-test stage between the raw entropy-source sampler and the TRNG control unit.
- Runs a Repetition Count Test (RCT) and an Adaptive Proportion Test (APT) on the sampled raw bit stream.
- Produces the per-event error pulse and the sticky total-failure flag that the control unit consumes.
- Honours the control unit's enable and flush outputs.

---
 rtl/trng_health_test_if.sv | 35 +++
 rtl/trng_health_test.sv | 196 +++++++++++++++++++
 tb/tb_trng_health_test.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/trng_health_test_if.sv
// Sample-stream and health-status bundle between the entropy sampler/control unit and trng_health_test.
// Optional TRNG_HT_STATS_EN adds the 16-bit failure-statistics outputs.
interface trng_health_test_if #(
    parameter int MAX_FAILS = 3
);
    localparam int FW = $clog2(MAX_FAILS + 1);

    logic          enable_i;
    logic          flush_i;
    logic          bit_valid_i;
    logic          bit_i;
    logic          error_o;
    logic          total_failure_o;
    logic [FW-1:0] fail_cnt_o;
`ifdef TRNG_HT_STATS_EN
    logic [15:0]   rct_fail_total_o;
    logic [15:0]   apt_fail_total_o;
`endif

    modport master (
        output enable_i, flush_i, bit_valid_i, bit_i,
`ifdef TRNG_HT_STATS_EN
        input  rct_fail_total_o, apt_fail_total_o,
`endif
        input  error_o, total_failure_o, fail_cnt_o
    );

    modport slave (
        input  enable_i, flush_i, bit_valid_i, bit_i,
`ifdef TRNG_HT_STATS_EN
        output rct_fail_total_o, apt_fail_total_o,
`endif
        output error_o, total_failure_o, fail_cnt_o
    );
endinterface

// File: rtl/trng_health_test.sv
// Online TRNG health test: Repetition Count Test plus Adaptive Proportion Test with sticky total failure.
// Defining TRNG_HT_STATS_EN adds saturating RCT/APT failure totals on the interface.
module trng_health_test #(
    parameter int RCT_CUTOFF = 32,
    parameter int APT_WINDOW = 512,
    parameter int APT_CUTOFF = 410,
    parameter int MAX_FAILS  = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    trng_health_test_if.slave  ht
);
    localparam int RCW = $clog2(RCT_CUTOFF + 1);
    localparam int AW  = $clog2(APT_WINDOW + 1);
    localparam int FW  = $clog2(MAX_FAILS + 1);
    localparam logic [RCW-1:0] RCT_CUT = RCW'(RCT_CUTOFF);
    localparam logic [AW-1:0]  APT_CUT = AW'(APT_CUTOFF);
    localparam logic [AW-1:0]  APT_WIN = AW'(APT_WINDOW);
    localparam logic [FW-1:0]  MAX_F   = FW'(MAX_FAILS);

    if ((APT_CUTOFF > APT_WINDOW) || (MAX_FAILS < 1)) begin : g_param_chk
        $error("trng_health_test: illegal APT_CUTOFF/APT_WINDOW/MAX_FAILS combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2,
        ST_DEAD  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            last_bit_q, last_bit_d;
    logic            apt_ref_q, apt_ref_d;
    logic [RCW-1:0]  rct_cnt_q, rct_cnt_d;
    logic [AW-1:0]   apt_cnt_q, apt_cnt_d;
    logic [AW-1:0]   apt_idx_q, apt_idx_d;
    logic [FW-1:0]   fail_cnt_q, fail_cnt_d;
    logic            error_q, error_d;
    logic            total_q, total_d;

    logic            new_ref_s;
    logic            apt_ref_upd_s;
    logic [RCW-1:0]  rct_upd_s;
    logic [AW-1:0]   apt_cnt_upd_s;
    logic [AW-1:0]   apt_idx_upd_s;
    logic [FW-1:0]   fail_inc_s;
    logic            rct_fail_s;
    logic            apt_fail_s;

`ifdef TRNG_HT_STATS_EN
    logic [15:0]     rct_tot_q, rct_tot_d;
    logic [15:0]     apt_tot_q, apt_tot_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
        if (inc && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction
`endif

    // Next-state, counter updates and failure evaluation for the current sample
    always_comb begin
        state_d    = state_q;
        last_bit_d = last_bit_q;
        apt_ref_d  = apt_ref_q;
        rct_cnt_d  = rct_cnt_q;
        apt_cnt_d  = apt_cnt_q;
        apt_idx_d  = apt_idx_q;
        fail_cnt_d = fail_cnt_q;
        error_d    = 1'b0;
        total_d    = total_q;
`ifdef TRNG_HT_STATS_EN
        rct_tot_d  = rct_tot_q;
        apt_tot_d  = apt_tot_q;
`endif

        // apt_idx_q==0 while running marks "next sample opens a new APT window"
        new_ref_s     = (state_q == ST_FIRST) || (apt_idx_q == {AW{1'b0}});
        rct_upd_s     = ((state_q == ST_FIRST) || (ht.bit_i != last_bit_q)) ? RCW'(1) : (rct_cnt_q + RCW'(1));
        apt_ref_upd_s = new_ref_s ? ht.bit_i : apt_ref_q;
        apt_cnt_upd_s = new_ref_s ? AW'(1) : (apt_cnt_q + AW'(ht.bit_i == apt_ref_q));
        apt_idx_upd_s = new_ref_s ? AW'(1) : (apt_idx_q + AW'(1));
        rct_fail_s    = (rct_upd_s == RCT_CUT);
        apt_fail_s    = (apt_cnt_upd_s == APT_CUT);
        fail_inc_s    = fail_cnt_q + FW'(1);

        case (state_q)
            ST_IDLE: begin
                if (ht.enable_i) begin
                    state_d = ST_FIRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST, ST_RUN: begin
                if (!ht.enable_i || ht.flush_i || (ht.bit_valid_i && (rct_fail_s || apt_fail_s))) begin
                    last_bit_d = 1'b0;
                    apt_ref_d  = 1'b0;
                    rct_cnt_d  = {RCW{1'b0}};
                    apt_cnt_d  = {AW{1'b0}};
                    apt_idx_d  = {AW{1'b0}};
                end else begin
                    last_bit_d = last_bit_q;
                end

                if (!ht.enable_i) begin
                    state_d = ST_IDLE;
                end else if (ht.flush_i) begin
                    state_d = ST_FIRST;
                end else if (ht.bit_valid_i) begin
                    if (rct_fail_s || apt_fail_s) begin
                        error_d    = 1'b1;
                        fail_cnt_d = fail_inc_s;
`ifdef TRNG_HT_STATS_EN
                        rct_tot_d  = sat_inc16(rct_tot_q, rct_fail_s);
                        apt_tot_d  = sat_inc16(apt_tot_q, apt_fail_s);
`endif
                        if (fail_inc_s == MAX_F) begin
                            state_d = ST_DEAD;
                            total_d = 1'b1;
                        end else begin
                            state_d = ST_FIRST;
                        end
                    end else begin
                        state_d    = ST_RUN;
                        last_bit_d = ht.bit_i;
                        rct_cnt_d  = rct_upd_s;
                        apt_ref_d  = apt_ref_upd_s;
                        if (apt_idx_upd_s == APT_WIN) begin
                            fail_cnt_d = {FW{1'b0}};
                            apt_cnt_d  = {AW{1'b0}};
                            apt_idx_d  = {AW{1'b0}};
                        end else begin
                            apt_cnt_d  = apt_cnt_upd_s;
                            apt_idx_d  = apt_idx_upd_s;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
                total_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            last_bit_q <= 1'b0;
            apt_ref_q  <= 1'b0;
            rct_cnt_q  <= {RCW{1'b0}};
            apt_cnt_q  <= {AW{1'b0}};
            apt_idx_q  <= {AW{1'b0}};
            fail_cnt_q <= {FW{1'b0}};
            error_q    <= 1'b0;
            total_q    <= 1'b0;
`ifdef TRNG_HT_STATS_EN
            rct_tot_q  <= 16'h0000;
            apt_tot_q  <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            last_bit_q <= last_bit_d;
            apt_ref_q  <= apt_ref_d;
            rct_cnt_q  <= rct_cnt_d;
            apt_cnt_q  <= apt_cnt_d;
            apt_idx_q  <= apt_idx_d;
            fail_cnt_q <= fail_cnt_d;
            error_q    <= error_d;
            total_q    <= total_d;
`ifdef TRNG_HT_STATS_EN
            rct_tot_q  <= rct_tot_d;
            apt_tot_q  <= apt_tot_d;
`endif
        end
    end

    assign ht.error_o         = error_q;
    assign ht.total_failure_o = total_q;
    assign ht.fail_cnt_o      = fail_cnt_q;
`ifdef TRNG_HT_STATS_EN
    assign ht.rct_fail_total_o = rct_tot_q;
    assign ht.apt_fail_total_o = apt_tot_q;
`endif

endmodule

// File: tb/tb_trng_health_test.sv
// Scoreboard bench for trng_health_test: each driven sample queues its hand-computed result,
// and a monitor checks the outputs in the cycle after every presented sample.
module tb_trng_health_test;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trng_health_test_if #(.MAX_FAILS(3)) ifc();

    trng_health_test dut (
        .clk_i (clk),
        .rst_i (rst),
        .ht    (ifc)
    );

    typedef struct packed {
        logic       err;
        logic       tot;
        logic [1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_seen = 0;
    logic en_v, fl_v, rs_v;

    // Drive one valid sample with the current control levels and queue the expected outputs
    task automatic step(input logic b, input logic e, input logic t, input logic [1:0] f);
        ifc.bit_valid_i = 1'b1;
        ifc.bit_i       = b;
        ifc.enable_i    = en_v;
        ifc.flush_i     = fl_v;
        rst             = rs_v;
        exp_q.push_back(exp_t'{err: e, tot: t, fc: f});
        @(posedge clk);
        #1;
    endtask

    task automatic fresh();
        rs_v = 1'b1;
        step(1'b0, 1'b0, 1'b0, 2'd0);
        rs_v = 1'b0;
        step(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic ones(input int n, input logic t, input logic [1:0] f);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, t, f);
    endtask

    // Monitor: outputs for a presented sample are compared on the following falling edge
    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(posedge clk);
            if (ifc.bit_valid_i === 1'b1) begin
                @(negedge clk);
                n_seen++;
                got = exp_t'{err: ifc.error_o, tot: ifc.total_failure_o, fc: ifc.fail_cnt_o};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow sample %0d: output seen with no expectation queued", n_seen);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL sample_chk #%0d: got err=%b tot=%b cnt=%0d, want err=%b tot=%b cnt=%0d",
                                 n_seen, got.err, got.tot, got.fc, want.err, want.tot, want.fc);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        en_v = 1'b0; fl_v = 1'b0; rs_v = 1'b1;
        rst = 1'b1;
        ifc.enable_i = 1'b0; ifc.flush_i = 1'b0;
        ifc.bit_valid_i = 1'b0; ifc.bit_i = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 2'd0);
        rs_v = 1'b0; en_v = 1'b1;
        step(1'b0, 1'b0, 1'b0, 2'd0);

        // 2000 alternating samples: never an error
        for (int i = 0; i < 2000; i++) step(i[0], 1'b0, 1'b0, 2'd0);

        // RCT: 10 alternating, 31 ones, a zero, then 32 ones -> error on the 32nd
        fresh();
        for (int i = 0; i < 10; i++) step(~i[0], 1'b0, 1'b0, 2'd0);
        ones(31, 1'b0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 2'd0);
        ones(31, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 2'd1);

        // APT: (31 ones + 1 zero) repeated, the 410th one is sample 423
        fresh();
        for (int i = 1; i <= 423; i++) begin
            if (i == 423) step(1'b1, 1'b1, 1'b0, 2'd1);
            else          step(((i - 1) % 32) != 31, 1'b0, 1'b0, 2'd0);
        end

        // Clean 512-sample window clears fail_cnt after the 512th sample
        for (int i = 1; i <= 512; i++) step(i[0] ^ 1'b1, 1'b0, 1'b0, (i == 512) ? 2'd0 : 2'd1);
        step(1'b0, 1'b0, 1'b0, 2'd0);

        // Flush mid-run: flushed sample discarded, RCT restarts
        ones(20, 1'b0, 2'd0);
        fl_v = 1'b1;
        step(1'b1, 1'b0, 1'b0, 2'd0);
        fl_v = 1'b0;
        ones(31, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 2'd1);

        // Same with reset: fail_cnt back to 0
        ones(20, 1'b0, 2'd1);
        rs_v = 1'b1;
        step(1'b1, 1'b0, 1'b0, 2'd0);
        rs_v = 1'b0;
        step(1'b1, 1'b0, 1'b0, 2'd0);
        ones(31, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 2'd1);

        // Enable drop clears test counters but holds fail_cnt
        ones(10, 1'b0, 2'd1);
        en_v = 1'b0;
        step(1'b1, 1'b0, 1'b0, 2'd1);
        en_v = 1'b1;
        step(1'b1, 1'b0, 1'b0, 2'd1);
        ones(31, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b0, 2'd2);

        // Three RCT failures -> total failure with the third pulse
        fresh();
        ones(31, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b0, 2'd1);
        ones(31, 1'b0, 2'd1);
        step(1'b1, 1'b1, 1'b0, 2'd2);
        ones(31, 1'b0, 2'd2);
        step(1'b1, 1'b1, 1'b1, 2'd3);

        // DEAD ignores enable, flush and samples
        en_v = 1'b0;
        step(1'b1, 1'b0, 1'b1, 2'd3);
        en_v = 1'b1; fl_v = 1'b1;
        step(1'b0, 1'b0, 1'b1, 2'd3);
        fl_v = 1'b0;
        ones(100, 1'b1, 2'd3);
        rs_v = 1'b1;
        step(1'b1, 1'b0, 1'b0, 2'd0);
        rs_v = 1'b0;
        step(1'b1, 1'b0, 1'b0, 2'd0);

        ifc.bit_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
